// File: rtl/arb_pkg.sv
// Shared constants, FSM encoding and the rotating-priority search for the
// four-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_GAP  = 2'b10
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walks the offsets from the highest down so the candidate closest to ptr
    // is written last and therefore wins, without needing an early exit.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface rr_arbiter_4_if;
    import arb_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               preempt;

    modport master (
        output en, req,
        input  gnt, gnt_idx, gnt_valid, preempt
    );

    modport slave (
        input  en, req,
        output gnt, gnt_idx, gnt_valid, preempt
    );

endinterface

// File: rtl/rr_arbiter_4_grant_decoder.sv
// Enable-gated 2-to-4 one-hot decoder that turns the registered winner index
// into the grant lines.
module grant_decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] onehot_o
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_dec
            assign onehot_o[gi] = en_i && (idx_i == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with hold-until-release, tenure preempt and a
// mandatory one-cycle gap between owners.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter_4_if.slave bus
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             preempt_q, preempt_d;
    pick_t            pick;
    logic             busy;
    logic [NUM_REQ-1:0] gnt_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        pick       = rr_pick(bus.req, ptr_q);

        case (state_q)
            S_IDLE, S_GAP: begin
                // The gap cycle doubles as an arbitration point, so the next
                // owner appears right after it.
                state_d = S_IDLE;
                if (bus.en && pick.found) begin
                    state_d    = S_BUSY;
                    idx_d      = pick.idx;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (!bus.en || !bus.req[idx_q]) begin
                    state_d = S_GAP;
                    ptr_d   = idx_q + IDX_W'(1);
                end else if (MAX_HOLD != 0 && hold_cnt_q == CNT_W'(MAX_HOLD)) begin
                    state_d   = S_GAP;
                    ptr_d     = idx_q + IDX_W'(1);
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == S_BUSY);
        bus.gnt_valid = busy;
        bus.gnt_idx   = idx_q;
        bus.preempt   = preempt_q;
        bus.gnt       = gnt_onehot;
    end

    grant_decoder u_gnt_dec (
        .idx_i    (idx_q),
        .en_i     (busy),
        .onehot_o (gnt_onehot)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: stimulus queues hand-computed expected
// outputs per clock, a monitor pops and compares them after each edge.
module tb_rr_arbiter_4;

    typedef struct packed {
        logic [3:0]  g;
        logic        p;
        logic [7:0]  tid;
        logic [15:0] step;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   step_n = 0;
    int   tid_n  = 0;
    exp_t exp_q[$];
    exp_t e_mon;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [1:0] oh_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic ok;
            e_mon = exp_q.pop_front();
            ok = (bus.gnt == e_mon.g) && (bus.gnt_valid == (|e_mon.g)) &&
                 (bus.preempt == e_mon.p) &&
                 (!(|e_mon.g) || bus.gnt_idx == oh_idx(e_mon.g));
            checks++;
            if (ok) begin
                passed++;
                $display("t%0d.s%0d gnt=%b idx=%0d valid=%b preempt=%b ok",
                         e_mon.tid, e_mon.step, bus.gnt, bus.gnt_idx,
                         bus.gnt_valid, bus.preempt);
            end else begin
                $display("FAIL t%0d.s%0d: got gnt=%b idx=%0d valid=%b preempt=%b, required gnt=%b idx=%0d valid=%b preempt=%b",
                         e_mon.tid, e_mon.step, bus.gnt, bus.gnt_idx, bus.gnt_valid,
                         bus.preempt, e_mon.g, oh_idx(e_mon.g), |e_mon.g, e_mon.p);
            end
        end
    end

    // Apply inputs, queue what the outputs must be after the next edge.
    task automatic cyc(input logic [3:0] r, input logic e,
                       input logic [3:0] eg, input logic ep);
        exp_t x;
        bus.req = r;
        bus.en  = e;
        step_n++;
        x.g = eg; x.p = ep; x.tid = 8'(tid_n); x.step = 16'(step_n);
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic rep(input int n, input logic [3:0] r, input logic e,
                       input logic [3:0] eg, input logic ep);
        for (int i = 0; i < n; i++) cyc(r, e, eg, ep);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.en  = 1'b1;
        #1;
        checks++;
        if (bus.gnt == 4'b0000 && bus.gnt_valid == 1'b0 &&
            bus.preempt == 1'b0 && bus.gnt_idx == 2'b00)
            passed++;
        else
            $display("FAIL t%0d async_rst: got gnt=%b idx=%0d valid=%b preempt=%b, required all zero",
                     tid_n, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step_n = 0;
        // Single requester holds then releases.
        tid_n = 1;
        do_reset();
        rep(5, 4'b0001, 1'b1, 4'b0001, 1'b0);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // All request, each owner releases after two grant cycles.
        tid_n = 2;
        do_reset();
        rep(2, 4'b1111, 1'b1, 4'b0001, 1'b0);
        cyc(4'b1110, 1'b1, 4'b0000, 1'b0);
        rep(2, 4'b1110, 1'b1, 4'b0010, 1'b0);
        cyc(4'b1100, 1'b1, 4'b0000, 1'b0);
        rep(2, 4'b1100, 1'b1, 4'b0100, 1'b0);
        cyc(4'b1000, 1'b1, 4'b0000, 1'b0);
        rep(2, 4'b1000, 1'b1, 4'b1000, 1'b0);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Tenure limit preempts and rotates between 0 and 2.
        tid_n = 3;
        do_reset();
        rep(8, 4'b0101, 1'b1, 4'b0001, 1'b0);
        cyc(4'b0101, 1'b1, 4'b0000, 1'b1);
        rep(8, 4'b0101, 1'b1, 4'b0100, 1'b0);
        cyc(4'b0101, 1'b1, 4'b0000, 1'b1);
        rep(2, 4'b0101, 1'b1, 4'b0001, 1'b0);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Disable ends owner 2's grant; resume from ptr=3.
        tid_n = 4;
        do_reset();
        rep(2, 4'b0100, 1'b1, 4'b0100, 1'b0);
        rep(3, 4'b1111, 1'b0, 4'b0000, 1'b0);
        rep(2, 4'b1111, 1'b1, 4'b1000, 1'b0);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Asynchronous reset mid-grant clears the pointer too.
        tid_n = 5;
        do_reset();
        rep(2, 4'b0100, 1'b1, 4'b0100, 1'b0);
        do_reset();
        rep(2, 4'b0110, 1'b1, 4'b0010, 1'b0);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Short pulse on req[3] while owner 1 is busy is lost.
        tid_n = 6;
        do_reset();
        cyc(4'b0010, 1'b1, 4'b0010, 1'b0);
        cyc(4'b1010, 1'b1, 4'b0010, 1'b0);
        cyc(4'b0010, 1'b1, 4'b0010, 1'b0);
        rep(3, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Release on the same edge the tenure limit is hit: no preempt.
        tid_n = 7;
        do_reset();
        rep(8, 4'b0001, 1'b1, 4'b0001, 1'b0);
        rep(2, 4'b0000, 1'b1, 4'b0000, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one resource among four requesters.
- Issues a one-hot grant plus the encoded winner index; the one-hot grant comes from a 2-to-4 enable-gated decode of the registered winner index.
- Sits between four request sources and the shared resource's select/enable lines.
- Supports a hold-until-release protocol, a maximum-tenure preempt and a global enable.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles for one owner; 0 = unlimited. Legal range 0..255.
- CNT_W, 8, width of the tenure counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  arbiter enable; 0 blocks new grants and ends the current grant
- req  in  4  request vector, bit i = requester i; held high for the whole tenure
- gnt  out  4  one-hot grant, all zero when no owner
- gnt_idx  out  2  encoded owner index; valid only when gnt_valid=1
- gnt_valid  out  1  high while any grant is active
- preempt  out  1  one-cycle pulse when a grant is ended by the MAX_HOLD limit

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, ptr=0, idx=0, hold_cnt=0
  - gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0
- States: IDLE, BUSY, GAP.
- Arbitration, evaluated in IDLE and GAP with en=1:
  - Search req from ptr upward, wrapping 3->0; first set bit wins.
  - Winner goes to idx, hold_cnt<=1, next state BUSY.
  - No set bit: stay in or go to IDLE.
- Latency: req sampled at edge N, so gnt is asserted in the cycle after edge N (one clock).
- gnt = decode(idx) gated by (state==BUSY); gnt_valid = (state==BUSY); gnt_idx = idx. All are decoded from registers only, with no combinational path from req.
- BUSY, evaluated each edge in this priority order:
  1. en=0 -> GAP, ptr<=idx+1 mod 4, no preempt.
  2. req[idx]=0 -> GAP, ptr<=idx+1.
  3. MAX_HOLD!=0 and hold_cnt==MAX_HOLD -> GAP, ptr<=idx+1, preempt<=1.
  4. Otherwise stay in BUSY, hold_cnt<=hold_cnt+1, saturating.
- GAP:
  - gnt=0000 for exactly one cycle, which guarantees break-before-make between owners.
  - Arbitration runs in the same cycle, so the next grant appears the cycle after GAP.
  - preempt is high only during the GAP cycle that follows a preempt.
- Fairness:
  - ptr always points one past the last owner.
  - A preempted requester that keeps req high becomes lowest priority.
  - Worst-case wait with MAX_HOLD=M is 3*(M+1)+1 cycles.
- Boundary conditions:
  - Requests arriving while BUSY are ignored until GAP; no queueing.
  - A req bit pulsed between arbitration points is lost.
  - en=0 in IDLE or GAP: no grant issued, stay in IDLE; ptr unchanged.
  - req[idx] dropping in the same cycle that hold_cnt==MAX_HOLD: treated as a normal release, no preempt.
  - MAX_HOLD=1: each tenure is exactly one cycle, followed by GAP.
  - rst_n low mid-grant: gnt goes to 0000 immediately (asynchronously) and all state clears; ptr=0 after reset.

Decomposition:
- Package arb_pkg:
  - localparams NUM_REQ=4, IDX_W=2
  - state encodings S_IDLE=2'b00, S_BUSY=2'b01, S_GAP=2'b10
- Sub-module grant_decoder:
  - Combinational 2-bit index + enable -> 4-bit one-hot.
  - Output is all zero when enable=0.
  - Instantiated once for gnt.
- FSM, pointer, tenure counter and priority search stay in rr_arbiter_4.

Test Plan:
1. Reset, then req=0001 held 5 cycles then dropped -> gnt=0001 from the cycle after first sample for 5 cycles, then 0000, preempt never 1.
2. req=1111 held, each owner drops its bit after 2 grant cycles -> grant order 0001,0010,0100,1000, each 2 cycles, separated by one 0000 GAP cycle.
3. MAX_HOLD=8, req=0101 held forever -> gnt=0001 for 8 cycles, GAP with preempt=1, then gnt=0100 for 8 cycles, preempt, then 0001 again.
4. Owner 2 granted, en driven 0 for 3 cycles -> next edge gnt=0000, no preempt, no grant while en=0; on en=1, arbitration resumes from ptr=3 (req=1111 -> gnt=1000).
5. rst_n pulsed low while gnt=0100 -> gnt=0000 and gnt_valid=0 asynchronously; after release with req=0110, gnt=0010 (ptr reset to 0).
6. req[3] pulsed for one cycle while owner 1 is BUSY -> no grant to 3; owner 1's release goes to IDLE.
